// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
package div_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } div_state_e;

  localparam int unsigned DivIter = 32;

endpackage

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU), one iteration per clock.
// Optional DIV_ZERO_FAST_EN: divide-by-zero completes on the accept edge.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DivIter,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  input  logic             sign,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remd_q, remd_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quot_step;
  logic [WIDTH-1:0] quot_fin;
  logic [WIDTH-1:0] rem_fin;

  always_comb begin
    rem_sh    = {rem_q, dvd_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, dvs_q};
    q_bit     = ~diff[WIDTH];
    rem_step  = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quot_step = {dvd_q[WIDTH-2:0], q_bit};
    // Zero divisor overrides the iterated result, using the raw dividend as latched.
    if (dvs_q == '0) begin
      quot_fin = '1;
      rem_fin  = a_raw_q;
    end else begin
      quot_fin = neg_q_q ? ('0 - quot_step) : quot_step;
      rem_fin  = neg_r_q ? ('0 - rem_step) : rem_step;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    a_raw_d = a_raw_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d   = (sign && a[WIDTH-1]) ? ('0 - a) : a;
          dvs_d   = (sign && b[WIDTH-1]) ? ('0 - b) : b;
          a_raw_d = a;
          rem_d   = '0;
          cnt_d   = '0;
          neg_q_d = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_d = sign & a[WIDTH-1];
          state_d = StBusy;
`ifdef DIV_ZERO_FAST_EN
          if (b == '0) begin
            state_d = StDone;
            quot_d  = '1;
            remd_d  = a;
          end
`endif
        end
      end
      StBusy: begin
        dvd_d = quot_step;
        rem_d = rem_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StDone;
          quot_d  = quot_fin;
          remd_d  = rem_fin;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      a_raw_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      a_raw_q <= a_raw_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = remd_q;
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corners plus random operands vs. an arithmetic model.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        sign;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;

  int checks;
  int errors;
  logic [31:0] last_q;
  logic [31:0] last_r;

  div_seq #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .start    (start),
    .sign     (sign),
    .quotient (quotient),
    .remainder(remainder),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain language-level division; returns {remainder, quotient}.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    logic [31:0] q;
    logic [31:0] r;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (!s) begin
      q = x / y;
      r = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end
    return {r, q};
  endfunction

  function automatic int exp_latency(input logic [31:0] y);
`ifdef DIV_ZERO_FAST_EN
    if (y == 32'd0) return 0;
`endif
    return 32;
  endfunction

  task automatic do_div(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    logic [63:0] exp;
    int n;
    int lat;
    exp = model(ta, tb, ts);
    lat = exp_latency(tb);
    @(negedge clk);
    a = ta;
    b = tb;
    sign = ts;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    if (lat != 0) begin
      repeat (5) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("hold_q", {32'd0, quotient}, {32'd0, last_q});
      check("hold_r", {32'd0, remainder}, {32'd0, last_r});
      a = $urandom;
      b = $urandom;
      sign = 1'($urandom);
    end
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(lat));
    check("quotient", {32'd0, quotient}, {32'd0, exp[31:0]});
    check("remainder", {32'd0, remainder}, {32'd0, exp[63:32]});
    last_q = exp[31:0];
    last_r = exp[63:32];
    @(posedge clk);
    #1;
    check("done_pulse", {63'd0, done}, 64'd0);
  endtask

  logic [31:0] da [8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
                          32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFF9, 32'h8000_0000};
  logic [31:0] db [8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                          32'd1, 32'd0, 32'd0, 32'd1};
  logic        ds [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int n;
    logic [31:0] ra;
    logic [31:0] rb;
    checks = 0;
    errors = 0;
    last_q = 32'd0;
    last_r = 32'd0;
    a = 32'd0;
    b = 32'd0;
    start = 1'b0;
    sign = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_q", {32'd0, quotient}, 64'd0);
    check("rst_r", {32'd0, remainder}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) do_div(da[i], db[i], ds[i]);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = rb >> $urandom_range(16, 31);
        1: rb = (i % 5 == 0) ? 32'd0 : rb;
        default: ;
      endcase
      do_div(ra, rb, 1'($urandom));
    end

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    a = 32'd100;
    b = 32'd7;
    sign = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_q", {32'd0, quotient}, 64'd0);
    check("midrst_r", {32'd0, remainder}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    last_q = 32'd0;
    last_r = 32'd0;
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    check("midrst_no_done", 64'(n), 64'd0);
    do_div(32'd9, 32'd3, 1'b0);

    // Back-to-back with start held high; operands change while busy.
    @(negedge clk);
    a = 32'd50;
    b = 32'd5;
    sign = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = $urandom;
    b = $urandom;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_lat1", 64'(n), 64'd32);
    check("b2b_q1", {32'd0, quotient}, 64'd10);
    check("b2b_r1", {32'd0, remainder}, 64'd0);
    a = 32'd81;
    b = 32'd9;
    @(posedge clk);
    #1;
    n = 1;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check("b2b_period", 64'(n), 64'd34);
    check("b2b_q2", {32'd0, quotient}, 64'd9);
    check("b2b_r2", {32'd0, remainder}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_idle", {63'd0, done}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
